hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be:
- REG_ADDR_LEN, 5: register address width; the scoreboard holds 2^REG_ADDR_LEN entries.
- FLUSH_CYCLES, 2: number of cycles IsFlush is held after a taken branch; legal range 1..15.
- MAX_STALL, 255: consecutive-stall watchdog limit.

REQ-002 Ports SHALL be:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  the ID stage holds an instruction.
- id_rs1_addr  in  REG_ADDR_LEN  source 1 register address.
- id_rs1_en  in  1  source 1 is read.
- id_rs2_addr  in  REG_ADDR_LEN  source 2 register address.
- id_rs2_en  in  1  source 2 is read.
- id_rd_addr  in  REG_ADDR_LEN  destination register address.
- id_rd_en  in  1  the instruction writes its destination.
- id_halt  in  1  the ID instruction is HALT.
- wb_valid  in  1  a writeback occurs this cycle.
- wb_addr  in  REG_ADDR_LEN  writeback register address.
- ex_branch_taken  in  1  EX resolved a taken branch.
- IsStall  out  1  freeze IF/ID.
- IsFlush  out  1  replace IF/ID contents with NOP.
- issue  out  1  the ID instruction advances to EX this cycle.
- halted  out  1  processor halted and drained.
- stall_cnt  out  16  saturating count of stall cycles.
- wdog_err  out  1  sticky watchdog error.

Function
REQ-003 The block SHALL keep a pending bit vector with one bit per register; bit 0 SHALL never be set.
REQ-004 hazard SHALL equal id_valid AND (id_rs1_en&pending[id_rs1_addr] OR id_rs2_en&pending[id_rs2_addr] OR id_rd_en&pending[id_rd_addr]), evaluated combinationally from the registered pending vector.
REQ-005 A same-cycle writeback SHALL NOT bypass: hazard stays set in the cycle wb_valid clears the bit.
REQ-006 The state machine SHALL have the states RUN, FLUSH, DRAIN and HALTED, encoded in 2 bits.
REQ-007 In RUN, IsStall SHALL equal hazard AND NOT ex_branch_taken.
REQ-008 In RUN, issue SHALL equal id_valid AND NOT hazard AND NOT ex_branch_taken.
REQ-009 In RUN, IsFlush SHALL equal ex_branch_taken.
REQ-010 In RUN, ex_branch_taken SHALL take priority over hazard: the state goes to FLUSH and the flush counter loads FLUSH_CYCLES-1.
REQ-011 In FLUSH, IsFlush SHALL be 1, IsStall 0 and issue 0; the counter decrements and the state returns to RUN in the cycle after the counter reaches 0.
REQ-012 With FLUSH_CYCLES=1, the state SHALL remain RUN: IsFlush is 1 for the branch cycle only, and the FLUSH state is never entered.
REQ-013 A new ex_branch_taken during FLUSH SHALL reload the counter to FLUSH_CYCLES-1.
REQ-014 When issue=1, id_rd_en=1 and id_rd_addr!=0, pending[id_rd_addr] SHALL be set at the next edge.
REQ-015 When wb_valid=1, pending[wb_addr] SHALL be cleared at the next edge.
REQ-016 When set and clear hit the same address in the same cycle, set SHALL win.
REQ-017 When issue=1 and id_halt=1, the state SHALL go to DRAIN.
REQ-018 In DRAIN, IsStall SHALL be 1 and issue 0; writebacks continue to clear pending bits.
REQ-019 DRAIN SHALL go to HALTED at the edge where pending==0 (evaluated after the same-cycle clear).
REQ-020 In HALTED, halted SHALL be 1 and IsStall 1; HALTED is exited only by rst.
REQ-021 ex_branch_taken SHALL be ignored in DRAIN and HALTED.
REQ-022 stall_cnt SHALL increment at each edge where IsStall=1 in RUN or DRAIN, and SHALL saturate at 16'hFFFF.
REQ-023 A consecutive-stall counter SHALL count cycles with IsStall=1 in RUN and clear on any cycle without a stall.
REQ-024 When the consecutive-stall counter exceeds MAX_STALL, wdog_err SHALL set and hold until rst.

Reset
REQ-025 With rst=1 at an edge, pending SHALL be 0, the state RUN, and all counters, halted and wdog_err 0.
REQ-026 rst SHALL take priority over all other inputs in the same cycle, including mid-FLUSH and mid-DRAIN.
REQ-027 During reset, the combinational outputs SHALL follow REQ-007 to REQ-009 using the reset pending value.

Verification
REQ-028 The bench SHALL cover RAW: issue rd=3, then ID reads rs1=3 -> IsStall=1 until wb_addr=3; issue=1 one cycle after the wb cycle; stall_cnt reflects the stall cycles.
REQ-029 The bench SHALL cover a taken branch with a simultaneous hazard, FLUSH_CYCLES=2 -> IsFlush=1 for 2 cycles, IsStall=0 and issue=0 throughout, then RUN.
REQ-030 The bench SHALL cover same-cycle issue rd=5 and wb_addr=5 -> pending[5]=1 afterwards.
REQ-031 The bench SHALL cover rd=0 writers -> pending stays 0 and no stall on a subsequent rs1=0 read.
REQ-032 The bench SHALL cover HALT issued with pending[7]=1 -> DRAIN, IsStall=1; wb_addr=7 -> halted=1 next edge; a later ex_branch_taken is ignored.
REQ-033 The bench SHALL cover MAX_STALL=4 with an unresolved hazard -> wdog_err=1 after 5 stall cycles; rst clears it and all state.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for an in-order pipeline. A scoreboard of pending
// destination registers drives the stall, flush and issue decisions. A small
// FSM sequences branch flushes and the HALT drain. Stall statistics and a
// watchdog on runaway stalls are kept alongside.
module hazard_ctrl #(
  parameter int REG_ADDR_LEN = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_STALL    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [REG_ADDR_LEN-1:0] id_rs1_addr,
  input  logic                    id_rs1_en,
  input  logic [REG_ADDR_LEN-1:0] id_rs2_addr,
  input  logic                    id_rs2_en,
  input  logic [REG_ADDR_LEN-1:0] id_rd_addr,
  input  logic                    id_rd_en,
  input  logic                    id_halt,
  input  logic                    wb_valid,
  input  logic [REG_ADDR_LEN-1:0] wb_addr,
  input  logic                    ex_branch_taken,
  output logic                    IsStall,
  output logic                    IsFlush,
  output logic                    issue,
  output logic                    halted,
  output logic [15:0]             stall_cnt,
  output logic                    wdog_err
);
  localparam int NREG = 1 << REG_ADDR_LEN;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_FLUSH  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  // A single-cycle flush is fully covered by the branch cycle itself.
  localparam bit USE_FLUSH = (FLUSH_CYCLES > 1);

  logic [NREG-1:0] pending, pending_n;
  logic [1:0]      state, state_n, cur;
  logic [3:0]      fcnt, fcnt_n;
  logic [15:0]     consec, consec_n;
  logic            hazard;

  // While rst is high the outputs behave as RUN with an empty scoreboard.
  assign cur    = rst ? S_RUN : state;
  assign hazard = ~rst & id_valid &
                  ((id_rs1_en & pending[id_rs1_addr]) |
                   (id_rs2_en & pending[id_rs2_addr]) |
                   (id_rd_en  & pending[id_rd_addr]));
  assign halted = (cur == S_HALTED);

  // Pipeline control outputs by state; a taken branch beats a hazard in RUN.
  always_comb begin
    IsStall = 1'b0;
    IsFlush = 1'b0;
    issue   = 1'b0;
    case (cur)
      S_RUN: begin
        IsStall = hazard & ~ex_branch_taken;
        IsFlush = ex_branch_taken;
        issue   = id_valid & ~hazard & ~ex_branch_taken;
      end
      S_FLUSH: IsFlush = 1'b1;
      default: IsStall = 1'b1;   // DRAIN and HALTED hold the front end
    endcase
  end

  // Scoreboard update: writeback clears first so a same-cycle set wins.
  always_comb begin
    pending_n = pending;
    if (wb_valid)
      pending_n[wb_addr] = 1'b0;
    if (issue && id_rd_en && (id_rd_addr != '0))
      pending_n[id_rd_addr] = 1'b1;
    pending_n[0] = 1'b0;
  end

  // FSM next state and flush countdown.
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    case (state)
      S_RUN: begin
        if (ex_branch_taken) begin
          fcnt_n = FLUSH_LOAD;
          if (USE_FLUSH) state_n = S_FLUSH;
        end else if (issue && id_halt) begin
          state_n = S_DRAIN;
        end
      end
      S_FLUSH: begin
        if (ex_branch_taken) begin
          fcnt_n = FLUSH_LOAD;
        end else begin
          fcnt_n = (fcnt == 4'd0) ? 4'd0 : fcnt - 4'd1;
          if (fcnt <= 4'd1) state_n = S_RUN;
        end
      end
      S_DRAIN: if (pending_n == '0) state_n = S_HALTED;
      default: state_n = S_HALTED;
    endcase
  end

  // Consecutive RUN stalls; DRAIN/HALTED stalls neither count nor clear.
  always_comb begin
    consec_n = consec;
    if (!IsStall)
      consec_n = '0;
    else if (state == S_RUN && consec != 16'hFFFF)
      consec_n = consec + 16'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      state     <= S_RUN;
      fcnt      <= '0;
      consec    <= '0;
      stall_cnt <= '0;
      wdog_err  <= 1'b0;
    end else begin
      pending <= pending_n;
      state   <= state_n;
      fcnt    <= fcnt_n;
      consec  <= consec_n;
      if (IsStall && (state == S_RUN || state == S_DRAIN) && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (32'(consec_n) > MAX_STALL)
        wdog_err <= 1'b1;
    end
  end

endmodule
